// File: rtl/temp_sensor_reader.sv
// SPI mode-0 master that periodically reads a 16-bit temperature sensor and
// reports the integer degC value (negative clamped to 0) plus the fault bit.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sclk,
  output logic       cs_n,
  input  logic       miso,
  output logic [7:0] temperature,
  output logic       temp_valid,
  output logic       fault,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for period counter == 0 and enable
  // SETUP  | cs_n low, first sclk half-period before rise 1
  // SHIFT  | clocking out 16 sclk pulses, sampling miso on rises
  // HOLD   | cs_n released, frame decoded on the next edge
  // UPDATE | temp_valid high for this one cycle
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE} state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LOAD = PW'(SAMPLE_PERIOD - 1);

  state_e        state_q;
  logic [PW-1:0] per_q;
  logic [DW-1:0] div_q;
  logic [5:0]    half_q;
  logic [15:0]   sr_q;
  logic          sclk_q, cs_n_q, valid_q, fault_q, busy_q;
  logic [7:0]    temp_q;

  logic [5:0]    half_d;
  logic          div_tc;

  assign half_d = half_q + 6'd1;
  assign div_tc = (div_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      temp_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      // Period counter free-runs (saturating) through the frame so starts are SAMPLE_PERIOD apart
      if (per_q != '0) per_q <= per_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (per_q == '0 && enable) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            per_q   <= PER_LOAD;
            div_q   <= DIV_LOAD;
            half_q  <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (div_tc) begin
            div_q   <= DIV_LOAD;
            half_q  <= half_d;
            state_q <= SHIFT;
            if (half_d == 6'd33) begin
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= HOLD;
            end else if (half_d[0]) begin
              sclk_q <= 1'b1;
              sr_q   <= {sr_q[14:0], miso};
            end else begin
              sclk_q <= 1'b0;
            end
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        HOLD: begin
          state_q <= UPDATE;
          valid_q <= 1'b1;
          fault_q <= sr_q[2];
          // A faulted frame keeps the last good temperature
          if (!sr_q[2]) temp_q <= sr_q[15] ? 8'd0 : {1'b0, sr_q[14:8]};
        end
        UPDATE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk        = sclk_q;
  assign cs_n        = cs_n_q;
  assign temperature = temp_q;
  assign temp_valid  = valid_q;
  assign fault       = fault_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: sensor model shifts frames on sclk fall and a
// scoreboard of expected {fault, temperature} is checked on each temp_valid.
module tb_temp_sensor_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sclk, cs_n;
  logic       miso = 1'b0;
  logic [7:0] temperature;
  logic       temp_valid, fault, busy;

  temp_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sclk(sclk), .cs_n(cs_n),
    .miso(miso), .temperature(temperature), .temp_valid(temp_valid),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_valid = 0;
  int t0 = 0;
  int rises = 0;
  int start_t[$];
  logic [15:0] fq[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  model_prev = 8'd0;
  logic [15:0] sh = 16'h0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] expect_of(input logic [15:0] f);
    logic [7:0] t;
    if (f[2]) t = model_prev;
    else      t = f[15] ? 8'd0 : {1'b0, f[14:8]};
    model_prev = t;
    return {f[2], t};
  endfunction

  always @(posedge clk) cyc++;

  // Sensor model and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        sh = (fq.size() > 0) ? fq.pop_front() : 16'h0000;
        exp_q.push_back(expect_of(sh));
        miso = sh[15];
        t0 = cyc;
        start_t.push_back(cyc);
        n_starts++;
        rises = 0;
      end
      if (!prev_cs && cs_n) begin
        chk("sclk_rises", rises, 16);
        chk("cs_low_len", cyc - t0, 66);
      end
      if (!prev_sclk && sclk) rises++;
      if (prev_sclk && !sclk && !cs_n) begin
        sh = sh << 1;
        miso = sh[15];
      end
      if (busy && temp_valid) chk("busy_valid_overlap", 1, 0);
      if (prev_valid && temp_valid) chk("valid_one_cycle", 1, 0);
      if (temp_valid) begin
        n_valid++;
        chk("valid_time", cyc - t0, 67);
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("temperature", int'(temperature), int'(e[7:0]));
          chk("fault", int'(fault), int'(e[8]));
        end
      end
      prev_cs = cs_n; prev_sclk = sclk; prev_valid = temp_valid;
    end
  end

  task automatic wait_valid(input int n, input int budget);
    int k = 0;
    while (n_valid < n && k < budget) begin @(posedge clk); k++; end
    if (n_valid < n) chk("timeout_valid", n_valid, n);
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin @(negedge clk); k++; end
    if (n_starts < n) chk("timeout_start", n_starts, n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, int'(cs_n), 1);
    chk({tag, "_sclk"}, int'(sclk), 0);
    chk({tag, "_temp"}, int'(temperature), 0);
    chk({tag, "_valid"}, int'(temp_valid), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int v_before;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Continuous run: basic, fractional, second value, negative, fault hold/recover
    fq.push_back(16'h1900); fq.push_back(16'h13F0); fq.push_back(16'h3200);
    fq.push_back(16'hF600); fq.push_back(16'h1900); fq.push_back(16'h3204);
    fq.push_back(16'h1E00);
    enable = 1'b1;
    reset  = 1'b0;
    wait_valid(7, 1200);
    for (int i = 1; i < 7 && i < start_t.size(); i++)
      chk("start_period", start_t[i] - start_t[i-1], 100);

    // Reset mid-frame
    fq.push_back(16'h1900);
    fq.push_back(16'h2800);
    wait_starts(8, 300);
    repeat (19) @(posedge clk);
    @(negedge clk);
    v_before = n_valid;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    model_prev = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_valid_after_abort", n_valid, v_before);
    chk("restart_after_reset", int'(cs_n), 0);
    wait_valid(8, 200);

    // Enable dropped mid-frame
    fq.push_back(16'h0A00);
    wait_starts(10, 300);
    repeat (10) @(posedge clk);
    enable = 1'b0;
    wait_valid(9, 200);
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("no_start_while_disabled", n_starts, 10);
    fq.push_back(16'h1400);
    enable = 1'b1;
    wait_valid(10, 300);
    chk("start_after_reenable", n_starts, 11);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
